// File: rtl/ir_key_dec.sv
// ir_key_dec: validates NEC frames and turns frames/repeat codes into press, auto-repeat and release events
module ir_key_dec #(
    parameter int         RPT_TIMEOUT_CYC = 6000000,
    parameter int         RPT_DELAY       = 2,
    parameter int         ADDR_FILTER_EN  = 0,
    parameter logic [7:0] ADDR_MATCH      = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_frame,
    input  logic        i_frame_vld,
    input  logic        i_rpt_vld,
    output logic [7:0]  o_key,
    output logic [7:0]  o_addr,
    output logic        o_key_vld,
    output logic        o_key_rpt,
    output logic        o_key_held,
    output logic        o_release,
    output logic        o_err,
    output logic [7:0]  o_err_cnt
);
    localparam int TW = (RPT_TIMEOUT_CYC > 2) ? $clog2(RPT_TIMEOUT_CYC) : 1;
    typedef enum logic [1:0] {IDLE, CHECK, HELD} state_t;
    state_t        r_state, w_state_nxt;
    logic [31:0]   r_frame;
    logic [TW-1:0] r_timer;
    logic [3:0]    r_rpt_cnt;
    logic          w_pass, w_timeout, w_rpt_ok;
    assign w_pass = ((r_frame[31:24] ^ r_frame[23:16]) == 8'hFF) &&
                    ((r_frame[15:8] ^ r_frame[7:0]) == 8'hFF) &&
                    (ADDR_FILTER_EN == 0 || r_frame[31:24] == ADDR_MATCH);
    assign w_timeout = r_timer == TW'(RPT_TIMEOUT_CYC - 1);
    assign w_rpt_ok  = 32'(r_rpt_cnt) >= RPT_DELAY;
    // A new frame always preempts whatever the current state is doing.
    always_comb begin
        w_state_nxt = r_state;
        if (i_frame_vld)
            w_state_nxt = CHECK;
        else if (r_state == CHECK)
            w_state_nxt = w_pass ? HELD : IDLE;
        else if (r_state == HELD && !i_rpt_vld && w_timeout)
            w_state_nxt = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_frame    <= '0;
            r_timer    <= '0;
            r_rpt_cnt  <= '0;
            o_key      <= '0;
            o_addr     <= '0;
            o_key_vld  <= 1'b0;
            o_key_rpt  <= 1'b0;
            o_key_held <= 1'b0;
            o_release  <= 1'b0;
            o_err      <= 1'b0;
            o_err_cnt  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            o_key_vld <= 1'b0;
            o_err     <= 1'b0;
            o_release <= 1'b0;
            if (i_frame_vld)
                r_frame <= i_frame;
            if (r_state == CHECK) begin
                if (w_pass) begin
                    o_key      <= r_frame[15:8];
                    o_addr     <= r_frame[31:24];
                    o_key_vld  <= 1'b1;
                    o_key_rpt  <= 1'b0;
                    o_key_held <= 1'b1;
                    r_timer    <= '0;
                    r_rpt_cnt  <= '0;
                end else begin
                    o_err      <= 1'b1;
                    o_key_held <= 1'b0;
                    if (o_err_cnt != 8'hFF)
                        o_err_cnt <= o_err_cnt + 8'd1;
                end
            end else if (r_state == HELD && !i_frame_vld) begin
                if (i_rpt_vld) begin
                    r_timer <= '0;
                    if (w_rpt_ok) begin
                        o_key_vld <= 1'b1;
                        o_key_rpt <= 1'b1;
                    end else if (r_rpt_cnt != 4'hF) begin
                        r_rpt_cnt <= r_rpt_cnt + 4'd1;
                    end
                end else if (w_timeout) begin
                    o_release  <= 1'b1;
                    o_key_held <= 1'b0;
                end else begin
                    r_timer <= r_timer + TW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_ir_key_dec.sv
// tb_ir_key_dec: random and directed stimulus against an event-schedule reference model with a scoreboard
module tb_ir_key_dec;
    localparam int         TMO   = 100;
    localparam int         DLY   = 2;
    localparam logic [7:0] MATCH = 8'h04;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] i_frame = '0;
    logic        i_frame_vld = 1'b0;
    logic        i_rpt_vld = 1'b0;
    logic [7:0]  o_key, o_addr, o_err_cnt;
    logic        o_key_vld, o_key_rpt, o_key_held, o_release, o_err;
    ir_key_dec #(
        .RPT_TIMEOUT_CYC(TMO),
        .RPT_DELAY(DLY),
        .ADDR_FILTER_EN(1),
        .ADDR_MATCH(MATCH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_frame(i_frame),
        .i_frame_vld(i_frame_vld),
        .i_rpt_vld(i_rpt_vld),
        .o_key(o_key),
        .o_addr(o_addr),
        .o_key_vld(o_key_vld),
        .o_key_rpt(o_key_rpt),
        .o_key_held(o_key_held),
        .o_release(o_release),
        .o_err(o_err),
        .o_err_cnt(o_err_cnt)
    );
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int checks = 0;
    int errors = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask
    // Expected events: kind is {key_vld, err, release}
    typedef struct {
        int         cyc;
        logic [2:0] kind;
        logic [7:0] key;
        logic [7:0] addr;
        logic [7:0] cnt;
        logic       rpt;
        logic       held;
    } ev_t;
    ev_t q[$];
    logic        m_pend, m_held;
    logic [31:0] m_fr;
    logic [7:0]  m_key, m_addr, m_cnt;
    int          m_dead, m_rpts;
    function automatic bit frame_ok(input logic [31:0] f);
        return (int'(f[23:16]) == 255 - int'(f[31:24])) &&
               (int'(f[7:0]) == 255 - int'(f[15:8])) && (f[31:24] == MATCH);
    endfunction
    task automatic push(input logic [2:0] kind, input logic rpt);
        ev_t e;
        e = '{cyc, kind, m_key, m_addr, m_cnt, rpt, m_held};
        q.push_back(e);
    endtask
    task automatic model_reset();
        m_pend = 0; m_held = 0; m_fr = '0; m_key = '0; m_addr = '0; m_cnt = '0;
        m_dead = 0; m_rpts = 0;
    endtask
    // One clock edge of the reference: a frame sampled last edge is judged now; HELD reacts to repeats and deadline.
    task automatic model(input logic f, input logic r, input logic [31:0] fr);
        if (m_pend) begin
            if (frame_ok(m_fr)) begin
                m_key = m_fr[15:8]; m_addr = m_fr[31:24]; m_held = 1; m_rpts = 0; m_dead = cyc + TMO;
                push(3'b100, 1'b0);
            end else begin
                if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
                m_held = 0;
                push(3'b010, 1'b0);
            end
        end else if (m_held && !f) begin
            if (r) begin
                m_dead = cyc + TMO;
                if (m_rpts >= DLY) push(3'b100, 1'b1);
                else m_rpts = m_rpts + 1;
            end else if (cyc == m_dead) begin
                m_held = 0;
                push(3'b001, 1'b0);
            end
        end
        m_pend = f;
        m_fr = fr;
    endtask
    task automatic step(input logic f, input logic r, input logic [31:0] fr);
        i_frame_vld = f; i_rpt_vld = r; i_frame = fr;
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else model(f, r, fr);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0);
    endtask
    task automatic chk_zero(input string nm);
        chk(nm, {o_key, o_addr, o_err_cnt, 3'b0, o_key_vld, o_key_rpt, o_key_held, o_release, o_err}, 32'h0);
    endtask
    ev_t me;
    always @(negedge clk) begin
        if ({o_key_vld, o_err, o_release} != 3'b000 && (q.size() == 0 || q[0].cyc != cyc)) begin
            checks++; errors++;
            $display("FAIL unexpected_event at cycle %0d: got vld/err/rel=%b, expected none", cyc,
                     {o_key_vld, o_err, o_release});
        end else if (q.size() != 0 && q[0].cyc == cyc) begin
            me = q.pop_front();
            chk("event_kind", 32'({o_key_vld, o_err, o_release}), 32'(me.kind));
            chk("held", 32'(o_key_held), 32'(me.held));
            if (me.kind == 3'b100) begin
                chk("key", 32'(o_key), 32'(me.key));
                chk("addr", 32'(o_addr), 32'(me.addr));
                chk("key_rpt", 32'(o_key_rpt), 32'(me.rpt));
            end
            if (me.kind == 3'b010) chk("err_cnt", 32'(o_err_cnt), 32'(me.cnt));
        end
    end
    function automatic logic [31:0] rnd_frame();
        logic [7:0] a, c, ai, ci;
        a = ($urandom_range(0, 1) == 1) ? MATCH : 8'($urandom);
        c = 8'($urandom);
        ai = ~a; ci = ~c;
        if ($urandom_range(0, 4) == 0) ci = ci ^ (8'd1 << $urandom_range(0, 7));
        if ($urandom_range(0, 9) == 0) ai = ai ^ (8'd1 << $urandom_range(0, 7));
        return {a, ai, c, ci};
    endfunction
    int rates[3] = '{0, 3, 12};
    initial begin
        model_reset();
        idle(3);
        chk_zero("reset_outputs");
        rst = 0;
        step(1'b1, 1'b0, 32'h04FB18E7);
        idle(3);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 32'h0);
            idle(49);
        end
        idle(110);
        step(1'b0, 1'b1, 32'h0);
        idle(3);
        chk("orphan_rpt_held", 32'(o_key_held), 32'h0);
        step(1'b1, 1'b0, 32'h04FB1818);
        idle(3);
        chk("bad_frame_key_kept", 32'(o_key), 32'h18);
        step(1'b1, 1'b0, 32'h00FF18E7);
        idle(3);
        for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 32'h04FB1818);
        idle(3);
        chk("err_cnt_saturated", 32'(o_err_cnt), 32'd255);
        step(1'b1, 1'b1, 32'h04FB2AD5);
        idle(3);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 32'h0);
            idle(10);
        end
        step(1'b1, 1'b0, 32'h04FB22DD);
        step(1'b1, 1'b0, 32'h04FB33CC);
        idle(5);
        rst = 1;
        step(1'b0, 1'b0, 32'h0);
        chk_zero("reset_while_held");
        rst = 0;
        for (int b = 0; b < 15; b++) begin
            int rate;
            rate = rates[$urandom_range(0, 2)];
            for (int i = 0; i < 200; i++) begin
                logic f, r;
                f = $urandom_range(0, 99) < 3;
                r = $urandom_range(0, 99) < rate;
                step(f, r, f ? rnd_frame() : 32'h0);
            end
        end
        idle(TMO + 20);
        chk("queue_drained", 32'(q.size()), 32'd0);
        chk("final_err_cnt", 32'(o_err_cnt), 32'(m_cnt));
        chk("final_held", 32'(o_key_held), 32'(m_held));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ir_key_dec.md
Name: ir_key_dec

Overview:
Downstream consumer of the NEC IR receiver's 32-bit frame word. Validates address/command complement pairs and optionally filters on address. Tracks NEC repeat codes to produce key-press, auto-repeat and key-release events. Feeds the key-handling and display logic with a clean 8-bit key code plus single-cycle event strobes.

Parameters:
RPT_TIMEOUT_CYC, 6000000, clocks without a frame or repeat before a held key is released (120 ms at 50 MHz)
RPT_DELAY, 2, repeat codes swallowed after a press before auto-repeat events start
ADDR_FILTER_EN, 0, 1 = reject frames whose address differs from ADDR_MATCH
ADDR_MATCH, 8'h00, accepted address when filtering is enabled

Ports:
clk  input  1  system clock (50 MHz)
rst  input  1  synchronous, active-high reset
i_frame  input  32  NEC word: [31:24] addr, [23:16] ~addr, [15:8] cmd, [7:0] ~cmd
i_frame_vld  input  1  one-cycle strobe; i_frame valid in that cycle
i_rpt_vld  input  1  one-cycle strobe; NEC repeat code (9 ms/2.25 ms leader) received
o_key  output  8  last accepted command byte
o_addr  output  8  last accepted address byte
o_key_vld  output  1  one-cycle key event (press or auto-repeat)
o_key_rpt  output  1  qualifies o_key_vld: 1 = auto-repeat event, 0 = new press
o_key_held  output  1  level: a key is currently held
o_release  output  1  one-cycle strobe when a held key times out
o_err  output  1  one-cycle strobe when a frame fails the checks
o_err_cnt  output  8  saturating count of rejected frames

Behaviour:
- One clock domain. Reset is synchronous and active-high. All outputs reset to 0. State resets to IDLE. Timer and repeat counter reset to 0.
- Every i_frame_vld loads the capture register, in any state. Next state is CHECK.
- Strobe outputs are registered. o_key_vld, o_err and o_release each assert for exactly 1 clock.
- CHECK (one cycle):
  - Pass condition: (addr ^ ~addr) == 8'hFF, (cmd ^ ~cmd) == 8'hFF, and (ADDR_FILTER_EN == 0 or addr == ADDR_MATCH).
  - Pass: load o_key = cmd and o_addr = addr; pulse o_key_vld with o_key_rpt = 0; set o_key_held = 1; clear timer and rpt_cnt; go to HELD.
  - Fail: pulse o_err; o_err_cnt += 1, saturating at 255; clear o_key_held without pulsing o_release; o_key and o_addr keep their old values; go to IDLE.
- Press latency: o_key_vld is high in the 2nd clock after the edge that samples i_frame_vld.
- HELD:
  - Timer increments every clock.
  - i_rpt_vld: clear the timer. If rpt_cnt >= RPT_DELAY, pulse o_key_vld with o_key_rpt = 1 and o_key unchanged. Otherwise rpt_cnt += 1, saturating (4-bit).
  - Timer reaching RPT_TIMEOUT_CYC-1: pulse o_release, clear o_key_held, go to IDLE.
- IDLE: i_rpt_vld is ignored (orphan repeat). No error is flagged.
- Simultaneous i_frame_vld and i_rpt_vld: the frame wins and the repeat is dropped.
- i_frame_vld while in CHECK: the current check still completes and produces its outputs. The new frame is captured and checked in the following cycle.
- A new valid frame while in HELD is treated as a fresh press: o_key_rpt = 0, rpt_cnt cleared, timer cleared. The previous key gets no o_release.
- Timer width is ceil(log2(RPT_TIMEOUT_CYC)). Comparison is unsigned.
- rst asserted mid-operation: next clock state is IDLE and all outputs are 0, including o_err_cnt. Any in-flight frame is discarded.

Test Plan:
- Valid press: i_frame=32'h00FF18E7 with a 1-cycle strobe -> two clocks later o_key_vld=1 for 1 cycle, o_key=8'h18, o_addr=8'h00, o_key_rpt=0, o_key_held=1.
- Bad complement: i_frame=32'h00FF1818 -> o_err pulses once, o_err_cnt=1, o_key_vld stays 0, o_key unchanged; repeat 300 bad frames -> o_err_cnt saturates at 255.
- Auto-repeat with RPT_DELAY=2 after press 8'h18: 4 i_rpt_vld strobes 50 cycles apart -> first 2 give no event, 3rd and 4th each give o_key_vld=1 with o_key_rpt=1 and o_key=8'h18.
- Release with RPT_TIMEOUT_CYC=100: press, then no further strobes -> o_release pulses exactly 100 clocks after HELD entry and o_key_held falls; a later i_rpt_vld produces nothing.
- Address filter with ADDR_FILTER_EN=1, ADDR_MATCH=8'h04: frame 32'h00FF18E7 -> o_err pulses; frame 32'h04FB18E7 -> key accepted with o_addr=8'h04.
- Collisions and reset: i_frame_vld and i_rpt_vld in the same cycle -> press only, rpt_cnt=0; rst pulsed while HELD -> all outputs 0 the next clock, state IDLE.
